// File: rtl/reg_bank_responder.sv
// reg_bank_responder: one bank of the G register file with a 32-slot write queue drained into it on commit (build option RBANK_FWD_EN adds read forwarding).
// Latency: ack one cycle after a request is sampled in IDLE; a commit drain scans 32 slots in 32 cycles.
// Backpressure: level-held four-phase requests; nothing is accepted during a drain, the requester simply keeps req high.
module reg_bank_responder #(
    parameter int unsigned BANK_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [6:0]  reg_id,
    input  logic [4:0]  queue_id,
    input  logic [31:0] write_data,
    input  logic        commit,
    input  logic        flush,
    output logic [31:0] read_data,
    output logic        ack,
    output logic        alignment_err,
    output logic        commit_done
);

    localparam logic [1:0] BANK = BANK_ID[1:0];

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW,
        COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    // Packed storage so reset can clear whole arrays in one assignment
    logic [31:0][31:0] arch;
    logic [31:0]       q_vld;
    logic [31:0][4:0]  q_idx;
    logic [31:0][31:0] q_dat;
    logic [4:0]        scan_idx;

    logic        any_req;
    logic        bad_req;
    logic        accept;
    logic        drain_en;
    logic [4:0]  rd_idx;
    logic [31:0] rd_val;

    assign any_req = read_req | write_req;
    assign bad_req = (read_req & write_req) | (reg_id[1:0] != BANK);
    assign rd_idx  = reg_id[6:2];

    // Read value: architectural register, optionally overridden by the lowest-numbered matching queued write
    always_comb begin
        rd_val = arch[rd_idx];
`ifdef RBANK_FWD_EN
        for (int i = 31; i >= 0; i--) begin
            if (q_vld[i] && (q_idx[i] == rd_idx)) begin
                rd_val = q_dat[i];
            end
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control: commit beats a request in IDLE, flush beats commit and aborts a drain
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        drain_en    = 1'b0;
        ack         = 1'b0;
        commit_done = 1'b0;
        case (state)
            IDLE: begin
                if (commit && !flush) begin
                    state_nxt = COMMIT;
                end else if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                ack       = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!any_req) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    drain_en = 1'b1;
                    if (scan_idx == 5'd31) begin
                        commit_done = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request service, queue fill, drain scan and flush (flush applied last so it wins)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arch          <= '0;
            q_vld         <= '0;
            q_idx         <= '0;
            q_dat         <= '0;
            scan_idx      <= '0;
            read_data     <= '0;
            alignment_err <= 1'b0;
        end else begin
            scan_idx <= drain_en ? scan_idx + 5'd1 : 5'd0;
            if (drain_en && q_vld[scan_idx]) begin
                arch[q_idx[scan_idx]] <= q_dat[scan_idx];
                q_vld[scan_idx]       <= 1'b0;
            end
            if (accept) begin
                if (bad_req) begin
                    alignment_err <= 1'b1;
                end else begin
                    alignment_err <= 1'b0;
                    if (write_req) begin
                        q_vld[queue_id] <= 1'b1;
                        q_idx[queue_id] <= rd_idx;
                        q_dat[queue_id] <= write_data;
                    end else begin
                        read_data <= rd_val;
                    end
                end
            end
            if (flush) begin
                q_vld <= '0;
            end
        end
    end

endmodule

// File: doc/reg_bank_responder.md
REG_BANK_RESPONDER -- requirements
Module: reg_bank_responder

Interface
REQ-001 The block SHALL have parameter BANK_ID, default 0, meaning the bank index 0-3; this bank owns G registers with reg_id[1:0]==BANK_ID.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port read_req, input, 1 bit: read request, level, held until ack.
REQ-005 The block SHALL have port write_req, input, 1 bit: write request, level, held until ack.
REQ-006 The block SHALL have port reg_id, input, 7 bits: G register ID 0-127.
REQ-007 The block SHALL have port queue_id, input, 5 bits: read/write queue slot 0-31.
REQ-008 The block SHALL have port write_data, input, reg_data_t (32 bits): write payload.
REQ-009 The block SHALL have port commit, input, 1 bit: one-cycle pulse to drain the write queue into the register file.
REQ-010 The block SHALL have port flush, input, 1 bit: one-cycle pulse to discard all pending writes.
REQ-011 The block SHALL have port read_data, output, reg_data_t (32 bits): read response.
REQ-012 The block SHALL have port ack, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port alignment_err, output, 1 bit: error flag, valid when ack=1.
REQ-014 The block SHALL have port commit_done, output, 1 bit: one-cycle pulse when the drain finishes.

Function
REQ-015 Storage SHALL be 32 architectural 32-bit registers indexed by reg_id[6:2], plus a 32-entry write queue indexed by queue_id; each entry holds valid, a 5-bit register index and 32-bit data.
REQ-016 The FSM SHALL have states IDLE, ACK, WAIT_LOW and COMMIT.
REQ-017 In IDLE, a request is sampled in cycle N; ack SHALL be 1 in cycle N+1 only (state ACK), and read_data and alignment_err SHALL update in that same cycle.
REQ-018 After ACK, the FSM SHALL enter WAIT_LOW and return to IDLE only when read_req=0 and write_req=0 (four-phase handshake, so there is no double accept).
REQ-019 If reg_id[1:0]!=BANK_ID, the block SHALL respond with ack and alignment_err=1 and change no state; read_data SHALL hold its previous value.
REQ-020 If read_req and write_req are both 1, the block SHALL respond with ack and alignment_err=1 and change no state.
REQ-021 An aligned write SHALL set queue entry [queue_id] to valid, index reg_id[6:2], data write_data; an already-valid entry SHALL be overwritten.
REQ-022 An aligned read SHALL return the architectural register reg_id[6:2], or the forwarded value defined in REQ-031.
REQ-023 When commit=1 in IDLE, the FSM SHALL enter COMMIT and scan entries 0 to 31, one entry per cycle; each valid entry is written to its register and cleared; 32 cycles total.
REQ-024 On the last scan cycle, commit_done SHALL be 1 for one cycle and the FSM SHALL return to IDLE.
REQ-025 While in COMMIT, requests SHALL NOT be accepted; ack stays 0 and the requester keeps req held.
REQ-026 commit asserted in ACK, WAIT_LOW or COMMIT SHALL be ignored.
REQ-027 When commit and a request arrive in the same IDLE cycle, commit SHALL win and the request is served after the drain.
REQ-028 flush in any state SHALL clear all queue valid bits next cycle.
REQ-029 flush in COMMIT SHALL abort the drain: FSM to IDLE, no commit_done, and already-drained registers keep their new values.
REQ-030 flush and commit in the same cycle: flush SHALL win.

Reset
REQ-031 Forwarding rule (RBANK_FWD_EN defined only): a read whose index matches one or more valid queue entries SHALL return the data of the lowest-numbered matching entry.
REQ-032 With rst_n=0 at a clk edge, the block SHALL reset: FSM to IDLE; all registers, queue valid bits and data to 0; read_data=0, ack=0, alignment_err=0, commit_done=0.
REQ-033 Reset SHALL abort any in-progress handshake or drain with no partial commit after the reset edge.

Configuration
REQ-034 The macro RBANK_FWD_EN SHALL control forwarding: when defined, reads forward from the write queue per REQ-031; when undefined, reads return architectural values only and the match logic is absent.

Verification
REQ-035 BANK_ID=1, write reg_id=5, queue_id=3, data 0xDEADBEEF -> ack one cycle after req, alignment_err=0; after commit, read reg 5 returns 0xDEADBEEF and commit_done comes 32 cycles after commit.
REQ-036 BANK_ID=1, read reg_id=6 -> ack with alignment_err=1; a following aligned read shows read_data unchanged by the error response.
REQ-037 Write reg 9 via queue 7 = 0x11 and via queue 2 = 0x22, then read reg 9 before commit -> 0x22 with RBANK_FWD_EN, 0x0 without.
REQ-038 Hold req high for 5 cycles after ack -> exactly one ack; after req goes low, a new request is acked normally.
REQ-039 Queue 0 and queue 31 valid, commit, flush at drain cycle 10 -> entry 0 committed, entry 31 discarded, no commit_done.
REQ-040 rst_n=0 during COMMIT -> next cycle all outputs are 0, every register reads 0, and the FSM is in IDLE.
